// File: rtl/ram_io_responder.sv
// Bus target for the memory controller: byte RAM plus a small I/O window
// (transmit FIFO, one-byte receive register, halt strobe) answered with one-cycle latency.
module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready,
  output logic        sim_halt,
  output logic        tx_overflow
);

  localparam int          PW      = $clog2(TX_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(TX_DEPTH);
  localparam logic [PW:0] HIGH_C  = (PW+1)'(TX_DEPTH - 2);
  localparam logic [31:0] IO_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_STAT = 32'h0003_0004;

  logic [7:0] ram     [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] tx_mem  [0:TX_DEPTH-1];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    mem_din_q, mem_din_d, rx_data_q, rx_data_d;
  logic          rx_full_q, rx_full_d, ovf_q, ovf_d, halt_q, halt_d;
  logic          buf_full_q, buf_full_d;

  logic                  io_sel, data_hit, stat_hit, tx_full;
  logic                  tx_pop, tx_push_req, tx_push, rx_pop, rx_fill, ram_we;
  logic [ADDR_WIDTH-1:0] idx;

  always_comb begin
    io_sel      = (mem_a[17:16] == 2'b11);
    idx         = mem_a[ADDR_WIDTH-1:0];
    data_hit    = (mem_a == IO_DATA);
    stat_hit    = (mem_a == IO_STAT);
    tx_full     = (count_q == DEPTH_C);
    // Host-side handshakes run regardless of rdy_in; only bus-side actions are gated.
    tx_pop      = (count_q != '0) && io_tx_ready;
    tx_push_req = rdy_in && mem_wr && data_hit;
    tx_push     = tx_push_req && (!tx_full || tx_pop);
    rx_pop      = rdy_in && !mem_wr && data_hit && rx_full_q;
    io_rx_ready = !rx_full_q || rx_pop;
    rx_fill     = io_rx_valid && io_rx_ready;
    ram_we      = rdy_in && mem_wr && !io_sel && !rst_in;

    rd_ptr_d  = rd_ptr_q + PW'(tx_pop);
    wr_ptr_d  = wr_ptr_q + PW'(tx_push);
    count_d   = count_q + (PW+1)'(tx_push) - (PW+1)'(tx_pop);
    ovf_d     = ovf_q | (tx_push_req & ~tx_push);
    halt_d    = rdy_in && mem_wr && stat_hit;
    buf_full_d = (count_d >= HIGH_C);

    rx_full_d = rx_full_q;
    rx_data_d = rx_data_q;
    if (rx_pop) rx_full_d = 1'b0;
    if (rx_fill) begin
      rx_full_d = 1'b1;
      rx_data_d = io_rx_data;
    end

    mem_din_d = mem_din_q;
    if (rdy_in && !mem_wr) begin
      if (!io_sel)       mem_din_d = ram[idx];
      else if (data_hit) mem_din_d = rx_full_q ? rx_data_q : 8'h00;
      else if (stat_hit) mem_din_d = {6'b0, tx_full, rx_full_q};
      else               mem_din_d = 8'h00;
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[idx] <= mem_dout;
    if (!rst_in && tx_push) tx_mem[wr_ptr_q] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      mem_din_q  <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_full_q  <= 1'b0;
      ovf_q      <= 1'b0;
      halt_q     <= 1'b0;
      buf_full_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_din_q  <= mem_din_d;
      rx_data_q  <= rx_data_d;
      rx_full_q  <= rx_full_d;
      ovf_q      <= ovf_d;
      halt_q     <= halt_d;
      buf_full_q <= buf_full_d;
    end
  end

  assign mem_din        = mem_din_q;
  assign io_tx_data     = tx_mem[rd_ptr_q];
  assign io_tx_valid    = (count_q != '0);
  assign io_buffer_full = buf_full_q;
  assign sim_halt       = halt_q;
  assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboarded bench: a queue/array reference model predicts read data and
// transmitted bytes; a monitor compares them as the DUT presents them.
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, mem_wr, io_tx_ready, io_rx_valid;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, io_rx_data;
  logic [7:0]  mem_din, io_tx_data;
  logic        io_buffer_full, io_tx_valid, io_rx_ready, sim_halt, tx_overflow;

  ram_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .io_tx_data(io_tx_data),
    .io_tx_valid(io_tx_valid), .io_tx_ready(io_tx_ready),
    .io_rx_data(io_rx_data), .io_rx_valid(io_rx_valid),
    .io_rx_ready(io_rx_ready), .sim_halt(sim_halt), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] ram_m [int];
  logic [7:0] txq [$];
  logic [7:0] exp_q [$];
  logic [7:0] tx_exp [$];
  logic       rx_full_m = 1'b0, ovf_m = 1'b0, halt_m = 1'b0;
  logic [7:0] rx_m = 8'h00, din_m = 8'h00;

  // per-step stimulus knobs
  logic       rdy_v = 1'b1, txr_v = 1'b0, rxv_v = 1'b0, rst_v = 1'b0;
  logic [7:0] rxd_v = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d);
    logic       iosel, h0, h4, pop, push, cpu_pop, rx_rdy;
    logic [7:0] e;
    @(negedge clk_in);
    rst_in = rst_v; rdy_in = rdy_v; mem_a = a; mem_wr = wr; mem_dout = d;
    io_tx_ready = txr_v; io_rx_valid = rxv_v; io_rx_data = rxd_v;
    #1;
    iosel = (a[17:16] == 2'b11);
    h0 = (a == 32'h0003_0000);
    h4 = (a == 32'h0003_0004);
    if (rst_v) begin
      txq.delete();
      rx_full_m = 1'b0; ovf_m = 1'b0; halt_m = 1'b0; din_m = 8'h00;
    end else begin
      pop     = (txq.size() > 0) && txr_v;
      cpu_pop = rdy_v && !wr && h0 && rx_full_m;
      rx_rdy  = !rx_full_m || cpu_pop;
      chk("io_rx_ready", io_rx_ready, rx_rdy);
      halt_m = rdy_v && wr && h4;
      push = 1'b0;
      if (rdy_v && !wr) begin
        if (!iosel)  e = ram_m[int'(a[16:0])];
        else if (h0) e = rx_full_m ? rx_m : 8'h00;
        else if (h4) e = {6'b0, txq.size() == 8, rx_full_m};
        else         e = 8'h00;
        exp_q.push_back(e);
        din_m = e;
      end
      if (rdy_v && wr) begin
        if (!iosel) ram_m[int'(a[16:0])] = d;
        if (h0) begin
          if (txq.size() < 8 || pop) push = 1'b1;
          else ovf_m = 1'b1;
        end
      end
      if (pop) tx_exp.push_back(txq.pop_front());
      if (push) txq.push_back(d);
      if (cpu_pop) rx_full_m = 1'b0;
      if (rxv_v && rx_rdy) begin
        rx_full_m = 1'b1;
        rx_m = rxd_v;
      end
    end
    @(posedge clk_in);
    #2;
    chk("io_tx_valid", io_tx_valid, txq.size() != 0);
    chk("io_buffer_full", io_buffer_full, txq.size() >= 6);
    chk("tx_overflow", tx_overflow, ovf_m);
    chk("sim_halt", sim_halt, halt_m);
    chk("mem_din_state", mem_din, din_m);
  endtask

  // monitor: read data appears the cycle after the address; tx bytes on handshake
  initial begin
    logic       rd, txh;
    logic [7:0] txd;
    forever begin
      @(posedge clk_in);
      rd  = rdy_in && !mem_wr && !rst_in;
      txh = io_tx_valid && io_tx_ready && !rst_in;
      txd = io_tx_data;
      #1;
      if (rd) begin
        if (exp_q.size() == 0) chk("read_sb_empty", 1, 0);
        else chk("mem_din_read", mem_din, exp_q.pop_front());
      end
      if (txh) begin
        if (tx_exp.size() == 0) chk("tx_sb_empty", 1, 0);
        else chk("io_tx_data", txd, tx_exp.pop_front());
      end
    end
  end

  initial begin
    int r;
    logic [31:0] a, alias_hi;
    rst_in = 1'b1; rdy_in = 1'b1; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
    io_tx_ready = 1'b0; io_rx_valid = 1'b0; io_rx_data = '0;

    rst_v = 1'b1; step(0, 1'b0, 0); step(0, 1'b0, 0); rst_v = 1'b0;

    step(32'h10, 1'b1, 8'hA5);
    step(32'h10, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(i, 1'b1, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) step(i, 1'b0, 0);

    // fill and overflow the transmit FIFO, then drain it
    for (int i = 0; i < 9; i++) step(32'h30000, 1'b1, 8'h41);
    txr_v = 1'b1;
    for (int i = 0; i < 10; i++) step(32'h10, 1'b0, 0);
    txr_v = 1'b0;

    // receive register
    rxv_v = 1'b1; rxd_v = 8'h5A; step(32'h0, 1'b0, 0); rxv_v = 1'b0;
    step(32'h30004, 1'b0, 0);
    step(32'h30000, 1'b0, 0);
    step(32'h30004, 1'b0, 0);
    step(32'h30000, 1'b0, 0);

    // push into a full FIFO while popping: accepted, order preserved
    rst_v = 1'b1; step(0, 1'b0, 0); rst_v = 1'b0;
    for (int i = 1; i <= 8; i++) step(32'h30000, 1'b1, 8'(i));
    txr_v = 1'b1; step(32'h30000, 1'b1, 8'h09);
    for (int i = 0; i < 9; i++) step(32'h0, 1'b0, 0);
    txr_v = 1'b0;

    step(32'h30004, 1'b1, 8'hFF);
    step(32'h0, 1'b0, 0);

    // rdy_in low freezes bus side
    rdy_v = 1'b0;
    step(32'h10, 1'b1, 8'hFF);
    step(32'h30004, 1'b0, 0);
    rdy_v = 1'b1;
    step(32'h10, 1'b0, 0);
    step(32'h20010, 1'b0, 0);
    step(32'h30008, 1'b0, 0);

    // reset with bytes queued
    for (int i = 0; i < 3; i++) step(32'h30000, 1'b1, 8'hC0 + 8'(i));
    rst_v = 1'b1; step(0, 1'b0, 0); rst_v = 1'b0;

    // randomized traffic over a preloaded RAM window and the I/O map
    for (int i = 0; i < 16; i++) step(i, 1'b1, 8'($urandom));
    for (int n = 0; n < 400; n++) begin
      rdy_v = ($urandom_range(0, 7) != 0);
      txr_v = 1'($urandom);
      rxv_v = 1'($urandom);
      rxd_v = 8'($urandom);
      case ($urandom_range(0, 3))
        0: alias_hi = 32'h0;
        1: alias_hi = 32'h0002_0000;
        2: alias_hi = 32'h0004_0000;
        default: alias_hi = 32'h8000_0000;
      endcase
      a = alias_hi | 32'($urandom_range(0, 15));
      r = $urandom_range(0, 11);
      if (r <= 3)      step(a, 1'b0, 0);
      else if (r <= 5) step(a, 1'b1, 8'($urandom));
      else if (r <= 7) step(32'h30000, 1'b1, 8'($urandom));
      else if (r == 8) step(32'h30000, 1'b0, 0);
      else if (r == 9) step(32'h30004, 1'b0, 0);
      else if (r == 10) step(32'h30008, 1'($urandom), 8'($urandom));
      else             step(32'h30004, 1'b1, 8'($urandom));
    end
    rdy_v = 1'b1; txr_v = 1'b1; rxv_v = 1'b0;
    for (int i = 0; i < 10; i++) step(32'h0, 1'b0, 0);
    chk("read_sb_drained", exp_q.size(), 0);
    chk("tx_sb_drained", tx_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
